compress_sequencer: RTL and testbench
=====================================

# compress_sequencer

Sequencing controller for the row compression datapath. Accepts one row of `MAX_R_SIZE` words through a valid/ready handshake and latches its nonzero mask. It then streams only the nonzero words out, one per accepted beat, in ascending word index, each tagged with its source index. It sits between the row buffer feeding the compressor and the downstream packer, and replaces free-running enable strobes with backpressure-aware sequencing.

## Interface
- `WORD_WIDTH`, 8, bits per word
- `MAX_R_SIZE`, 4, words per row (power of two, ≥2)
- `R_DIST_WIDTH`, 2, index width; must equal log2(`MAX_R_SIZE`)
- `CNT_WIDTH`, 16, width of the completed-row counter

- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high reset
- `in_valid` in 1: upstream row valid
- `in_ready` out 1: sequencer can accept a row
- `in_row` in `WORD_WIDTH*MAX_R_SIZE`: word i at bits [i*WORD_WIDTH +: WORD_WIDTH]
- `out_valid` out 1: compressed beat valid
- `out_ready` in 1: downstream accepts the beat
- `out_word` out `WORD_WIDTH`: nonzero word
- `out_idx` out `R_DIST_WIDTH`: source index of `out_word`
- `out_last` out 1: final beat of the current row
- `busy` out 1: a row is held (state EMIT)
- `row_cnt` out `CNT_WIDTH`: rows fully retired since reset

## Operation
- States: IDLE and EMIT.
- IDLE
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid && in_ready`: register `in_row` into `row_q`, and register `mask_q[i]` = (word i != 0).
  - If the mask is nonzero, go to EMIT.
  - If the mask is zero, apply the empty-row behaviour (see Configuration).
- EMIT
  - `in_ready`=0 and `out_valid`=1.
  - `sel` = lowest set index of `mask_q`. `out_word` = `row_q[sel]` and `out_idx` = `sel`.
  - `out_last`=1 when `mask_q` has exactly one bit set.
- On `out_valid && out_ready`: clear `mask_q[sel]`.
  - If this was the last beat: go to IDLE and increment `row_cnt`.
  - Otherwise stay in EMIT and move to the next set bit.
- Backpressure: while `out_valid && !out_ready`, `out_word`, `out_idx` and `out_last` hold stable. `mask_q` is unchanged.
- `in_ready` is a pure function of state. It does not depend on `out_ready`, so there is no combinational in-to-out path.
- `row_cnt` wraps modulo 2^`CNT_WIDTH`. Wrap produces no flag.
- Reset (any time, including mid-row): state=IDLE, `row_q`=0, `mask_q`=0, `row_cnt`=0. Any partially emitted row is discarded.
- Output values under reset: `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0. `out_word`/`out_idx` read 0 because `row_q`/`mask_q` are 0.

## Timing
- Row accepted at edge N: the first beat is valid in cycle N+1 (1-cycle latency).
- With `out_ready` held high, a row with k nonzero words occupies k cycles in EMIT. The next row can be accepted in the cycle after its last beat, so one row costs k+1 cycles.
- `row_cnt` updates on the same edge as the last handshake.
- All outputs are registered or decoded from registered state. Nothing is combinational from `in_valid`/`in_row`.

## Configuration
- `COMPRESS_EMPTY_MARKER_EN`
  - Defined: an all-zero row enters EMIT and produces one marker beat: `out_word`=0, `out_idx`=0, `out_last`=1. A `marker_q` flag marks this beat. `row_cnt` increments when the marker beat is handshaken.
  - Undefined: an all-zero row is consumed in its accept cycle. The sequencer stays in IDLE with `in_ready` still 1, emits no beat, and increments `row_cnt` on the accept edge. No `marker_q` flop exists.

## Structure
- Package `compress_pkg` holds:
  - state enum `cs_state_t` {CS_IDLE, CS_EMIT}
  - default parameter constants
  - the helper function for the index width
- One submodule, `lowest_one_picker`: combinational priority encoder.
  - Input: `MAX_R_SIZE`-bit mask.
  - Outputs: `sel` index, `onehot` clear vector, `single` (exactly one bit set).
- All state and counters live in `compress_sequencer`.

## Test plan
- Row {w3=0x00,w2=0x07,w1=0x00,w0=0x05} with `out_ready`=1:
  - beats (0x05,idx0,last0) then (0x07,idx2,last1)
  - `row_cnt` 0→1
  - `in_ready` high again on the following cycle
- Row {0x11,0x22,0x33,0x44} with `out_ready` low for 3 cycles on beat idx1: beat 0x33/idx1 holds stable for 4 cycles, then the remaining beats follow in order.
- All-zero row:
  - Macro defined: one beat (0x00,idx0,last1).
  - Macro undefined: no beat, `in_ready` stays 1, `row_cnt` increments the next cycle.
- Assert `reset` during the second beat of a 4-nonzero row: next cycle `out_valid`=0, `in_ready`=1, `row_cnt`=0. A new row then emits from idx0.
- With `CNT_WIDTH`=4, retire 17 rows: `row_cnt` reads 1.
- Back-to-back rows with `in_valid` held high: `in_ready` is low throughout EMIT, and the second row is accepted exactly one cycle after the first row's last beat.

Source files
------------

// File: rtl/compress_sequencer_pkg.sv
// compress_pkg: shared types and defaults for the row compression sequencer.
// Holds the sequencer state enum, default parameter values and the
// index-width helper used to size the word index from the row length.
package compress_pkg;

  typedef enum logic {CS_IDLE, CS_EMIT} cs_state_t;

  localparam int DEF_WORD_WIDTH   = 8;
  localparam int DEF_MAX_R_SIZE   = 4;
  localparam int DEF_R_DIST_WIDTH = 2;
  localparam int DEF_CNT_WIDTH    = 16;

  // Number of bits needed to index n words (at least one bit).
  function automatic int idx_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/compress_sequencer_if.sv
// compress_sequencer_if: row-in / beat-out handshake bundle.
// The slave modport is the sequencer view, the master modport is the
// view of whatever drives rows in and accepts compressed beats out.
interface compress_sequencer_if #(
  parameter int WORD_WIDTH   = compress_pkg::DEF_WORD_WIDTH,
  parameter int MAX_R_SIZE   = compress_pkg::DEF_MAX_R_SIZE,
  parameter int R_DIST_WIDTH = compress_pkg::idx_width(MAX_R_SIZE)
);

  logic                             in_valid;
  logic                             in_ready;
  logic [WORD_WIDTH*MAX_R_SIZE-1:0] in_row;
  logic                             out_valid;
  logic                             out_ready;
  logic [WORD_WIDTH-1:0]            out_word;
  logic [R_DIST_WIDTH-1:0]          out_idx;
  logic                             out_last;

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_word, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_word, out_idx, out_last
  );

endinterface

// File: rtl/compress_sequencer_lowest_one_picker.sv
// lowest_one_picker: combinational priority encoder over the nonzero mask.
// Reports the lowest set index, a one-hot vector to clear that bit, and
// whether exactly one bit is set (the current beat is the row's last).
module lowest_one_picker #(
  parameter int MAX_R_SIZE   = compress_pkg::DEF_MAX_R_SIZE,
  parameter int R_DIST_WIDTH = compress_pkg::idx_width(MAX_R_SIZE)
) (
  input  logic [MAX_R_SIZE-1:0]   mask,
  output logic [R_DIST_WIDTH-1:0] sel,
  output logic [MAX_R_SIZE-1:0]   onehot,
  output logic                    single
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    sel    = '0;
    onehot = '0;
    for (int i = MAX_R_SIZE - 1; i >= 0; i--) begin
      if (mask[i]) begin
        sel       = R_DIST_WIDTH'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
    single = (|mask) && ((mask & (mask - MAX_R_SIZE'(1))) == '0);
  end

endmodule

// File: rtl/compress_sequencer.sv
// compress_sequencer: accepts a row of words, then streams its nonzero
// words in ascending index order, one per accepted beat, with backpressure.
// Optional feature macro COMPRESS_EMPTY_MARKER_EN: when defined, an
// all-zero row yields one zero marker beat instead of vanishing silently.
module compress_sequencer
  import compress_pkg::*;
#(
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int MAX_R_SIZE   = DEF_MAX_R_SIZE,
  parameter int R_DIST_WIDTH = idx_width(MAX_R_SIZE),
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  compress_sequencer_if.slave   bus,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  row_cnt
);

  cs_state_t                        state, state_next;
  logic [WORD_WIDTH*MAX_R_SIZE-1:0] row_q;
  logic [MAX_R_SIZE-1:0]            mask_q;
  logic [MAX_R_SIZE-1:0]            in_mask;
  logic [R_DIST_WIDTH-1:0]          sel;
  logic [MAX_R_SIZE-1:0]            onehot;
  logic                             single;
  logic                             accept;
  logic                             fire;
  logic                             last_beat;
  logic                             marker;

  lowest_one_picker #(
    .MAX_R_SIZE  (MAX_R_SIZE),
    .R_DIST_WIDTH(R_DIST_WIDTH)
  ) u_picker (
    .mask  (mask_q),
    .sel   (sel),
    .onehot(onehot),
    .single(single)
  );

  // Build the nonzero mask of the incoming row word by word.
  always_comb begin
    in_mask = '0;
    for (int i = 0; i < MAX_R_SIZE; i++) begin
      in_mask[i] = |bus.in_row[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

`ifdef COMPRESS_EMPTY_MARKER_EN
  logic marker_q;

  // Flag that the row being emitted is the single zero marker beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   marker_q <= 1'b0;
    else if (accept)             marker_q <= ~|in_mask;
    else if (fire)               marker_q <= 1'b0;
  end

  assign marker = marker_q;
`else
  assign marker = 1'b0;
`endif

  assign accept    = bus.in_valid && bus.in_ready;
  assign fire      = bus.out_valid && bus.out_ready;
  assign last_beat = single || marker;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CS_IDLE;
    else       state <= state_next;
  end

  // Next state and handshake outputs decoded from the current state only.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    busy          = 1'b0;
    case (state)
      CS_IDLE: begin
        bus.in_ready = 1'b1;
`ifdef COMPRESS_EMPTY_MARKER_EN
        if (bus.in_valid) state_next = CS_EMIT;
`else
        if (bus.in_valid && (|in_mask)) state_next = CS_EMIT;
`endif
      end
      CS_EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_beat;
        busy          = 1'b1;
        if (bus.out_ready && last_beat) state_next = CS_IDLE;
      end
      default: state_next = CS_IDLE;
    endcase
  end

  // Capture the row on accept and retire one mask bit per handshaken beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q  <= '0;
      mask_q <= '0;
    end else if (accept) begin
      row_q  <= bus.in_row;
      mask_q <= in_mask;
    end else if (fire) begin
      mask_q <= mask_q & ~onehot;
    end
  end

  // Count rows retired: on the last beat, or on accept of a dropped empty row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt <= '0;
    end else if (fire && last_beat) begin
      row_cnt <= row_cnt + CNT_WIDTH'(1);
`ifndef COMPRESS_EMPTY_MARKER_EN
    end else if (accept && !(|in_mask)) begin
      row_cnt <= row_cnt + CNT_WIDTH'(1);
`endif
    end
  end

  assign bus.out_word = row_q[sel*WORD_WIDTH +: WORD_WIDTH];
  assign bus.out_idx  = sel;

endmodule

// File: tb/tb_compress_sequencer.sv
// tb_compress_sequencer: randomized and directed checks of compress_sequencer
// against a row-level model (list of nonzero words plus a retired-row count).
// Follows COMPRESS_EMPTY_MARKER_EN the same way the design does.
module tb_compress_sequencer;

  localparam int WW = 8;
  localparam int MR = 4;
  localparam int RD = 2;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          busy;
  logic [CW-1:0] row_cnt;

  int checks;
  int errors;
  int model_cnt;

  compress_sequencer_if #(.WORD_WIDTH(WW), .MAX_R_SIZE(MR), .R_DIST_WIDTH(RD)) bus ();

  compress_sequencer #(
    .WORD_WIDTH  (WW),
    .MAX_R_SIZE  (MR),
    .R_DIST_WIDTH(RD),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.slave),
    .busy   (busy),
    .row_cnt(row_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Accept one row, then follow every expected beat, optionally stalling.
  task automatic applyStimulus(input logic [31:0] row, input int stall_beat,
                               input int stall_cycles, input int stall_pct);
    logic [7:0] exp_word[$];
    int         exp_idx[$];
    logic [7:0] w;
    for (int i = 0; i < MR; i++) begin
      w = row[i*8 +: 8];
      if (w != 8'h00) begin
        exp_word.push_back(w);
        exp_idx.push_back(i);
      end
    end
`ifdef COMPRESS_EMPTY_MARKER_EN
    if (exp_word.size() == 0) begin
      exp_word.push_back(8'h00);
      exp_idx.push_back(0);
    end
`endif
    checkOutput("in_ready_idle", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.in_row    = row;
    bus.out_ready = 1'b0;
    stepCycle();
    bus.in_valid = 1'b0;
    bus.in_row   = $urandom;
    if (exp_word.size() == 0) begin
      model_cnt = (model_cnt + 1) % (1 << CW);
      checkOutput("empty_no_valid", bus.out_valid, 0);
      checkOutput("empty_in_ready", bus.in_ready, 1);
      checkOutput("empty_row_cnt", row_cnt, model_cnt);
      return;
    end
    for (int b = 0; b < exp_word.size(); b++) begin
      int stalls;
      bit done;
      stalls = 0;
      done   = 1'b0;
      while (!done) begin
        checkOutput("out_valid", bus.out_valid, 1);
        checkOutput("in_ready_emit", bus.in_ready, 0);
        checkOutput("busy", busy, 1);
        checkOutput("out_word", bus.out_word, exp_word[b]);
        checkOutput("out_idx", bus.out_idx, exp_idx[b]);
        checkOutput("out_last", bus.out_last, (b == exp_word.size() - 1) ? 1 : 0);
        checkOutput("row_cnt_mid", row_cnt, model_cnt);
        if ((b == stall_beat && stalls < stall_cycles) ||
            (stall_beat < 0 && stalls < 4 && $urandom_range(99) < stall_pct)) begin
          bus.out_ready = 1'b0;
          stalls++;
        end else begin
          bus.out_ready = 1'b1;
          done = 1'b1;
        end
        stepCycle();
      end
    end
    bus.out_ready = 1'b0;
    model_cnt = (model_cnt + 1) % (1 << CW);
    checkOutput("done_valid", bus.out_valid, 0);
    checkOutput("done_in_ready", bus.in_ready, 1);
    checkOutput("done_row_cnt", row_cnt, model_cnt);
  endtask

  task automatic randomRow(output logic [31:0] row);
    row = '0;
    for (int i = 0; i < MR; i++) begin
      if ($urandom_range(1) == 1) row[i*8 +: 8] = 8'($urandom_range(255, 1));
    end
  endtask

  initial begin
    logic [31:0] row;
    checks        = 0;
    errors        = 0;
    model_cnt     = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.out_ready = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_last", bus.out_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_row_cnt", row_cnt, 0);
    checkOutput("rst_out_word", bus.out_word, 0);
    reset = 1'b0;
    stepCycle();

    applyStimulus(32'h0007_0005, -1, 0, 0);
    applyStimulus(32'h1122_3344, 1, 3, 0);
    applyStimulus(32'h0000_0000, -1, 0, 0);

    // Back-to-back rows with in_valid held high.
    bus.in_valid  = 1'b1;
    bus.in_row    = 32'h0000_0102;
    bus.out_ready = 1'b1;
    stepCycle();
    bus.in_row = 32'h0030_0000;
    checkOutput("b2b_beat0_word", bus.out_word, 8'h02);
    checkOutput("b2b_beat0_ready", bus.in_ready, 0);
    stepCycle();
    checkOutput("b2b_beat1_word", bus.out_word, 8'h01);
    checkOutput("b2b_beat1_last", bus.out_last, 1);
    checkOutput("b2b_beat1_ready", bus.in_ready, 0);
    stepCycle();
    model_cnt = (model_cnt + 1) % (1 << CW);
    checkOutput("b2b_gap_ready", bus.in_ready, 1);
    checkOutput("b2b_gap_valid", bus.out_valid, 0);
    checkOutput("b2b_gap_cnt", row_cnt, model_cnt);
    stepCycle();
    bus.in_valid = 1'b0;
    checkOutput("b2b_row2_valid", bus.out_valid, 1);
    checkOutput("b2b_row2_word", bus.out_word, 8'h30);
    checkOutput("b2b_row2_idx", bus.out_idx, 2);
    checkOutput("b2b_row2_last", bus.out_last, 1);
    stepCycle();
    bus.out_ready = 1'b0;
    model_cnt = (model_cnt + 1) % (1 << CW);
    checkOutput("b2b_end_cnt", row_cnt, model_cnt);

    // Reset in the middle of a four-word row.
    bus.in_valid  = 1'b1;
    bus.in_row    = 32'h0102_0304;
    bus.out_ready = 1'b1;
    stepCycle();
    bus.in_valid = 1'b0;
    stepCycle();
    checkOutput("pre_rst_idx", bus.out_idx, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", bus.out_valid, 0);
    checkOutput("mid_rst_in_ready", bus.in_ready, 1);
    checkOutput("mid_rst_cnt", row_cnt, 0);
    checkOutput("mid_rst_word", bus.out_word, 0);
    stepCycle();
    reset         = 1'b0;
    bus.out_ready = 1'b0;
    model_cnt     = 0;
    stepCycle();
    applyStimulus(32'h0000_00A5, -1, 0, 0);

    // Seventeen rows from reset wrap a 4-bit counter to one.
    reset = 1'b1;
    stepCycle();
    reset     = 1'b0;
    model_cnt = 0;
    stepCycle();
    for (int r = 0; r < 17; r++) begin
      randomRow(row);
      applyStimulus(row, -1, 0, 30);
    end
    checkOutput("wrap17", row_cnt, 1);

    for (int r = 0; r < 30; r++) begin
      randomRow(row);
      applyStimulus(row, -1, 0, 40);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
